instr_decoder: RTL and testbench
================================

// Module: instr_decoder
// PURPOSE
// - Immediate-format decoder for the multi-cycle RV32I core controller.
// - Maps the 7-bit opcode (Instr[6:0]) to ImmSrc, the select for the immediate extender.
// - ImmSrc is combinational and valid in the same cycle as op, ready for the decode state.
// - Also provides a registered copy, a one-hot format class and an illegal-opcode flag for the FSM.
// PARAMETERS
// - EXT_OPS        1       1: also decode jalr (1100111) and auipc (0010111); 0: treat them as illegal
// - DEFAULT_IMMSRC 3'b000  ImmSrc driven for R-type and illegal opcodes
// PORTS
// - clk         in   1  rising-edge clock; single clock domain
// - reset       in   1  synchronous, active-high reset
// - op          in   7  opcode field Instr[6:0]
// - ImmSrc      out  3  combinational immediate-format select
// - ImmSrcR     out  3  ImmSrc registered on every clk edge
// - FmtR        out  6  registered one-hot class {U,J,B,S,I,R}, bit0 = R
// - IllegalR    out  1  registered: op not in the supported set
// BEHAVIOUR
// - ImmSrc is purely combinational from op and has zero latency; it does not depend on clk or reset.
// - ImmSrc encoding:
//   - I = 000: lw 0000011, addi-class 0010011, jalr 1100111 (jalr only when EXT_OPS=1)
//   - S = 001: sw 0100011
//   - B = 010: beq-class 1100011
//   - J = 011: jal 1101111
//   - U = 100: lui 0110111, auipc 0010111 (auipc only when EXT_OPS=1)
//   - R-type 0110011 has no immediate: ImmSrc = DEFAULT_IMMSRC, FmtR[0] = 1
//   - Any other op: ImmSrc = DEFAULT_IMMSRC, Illegal = 1, FmtR = 0
// - Codes 101, 110 and 111 are never produced.
// - op containing X/Z is treated as illegal; the design must still drive ImmSrc = DEFAULT_IMMSRC.
// - The decode is a full case on all 7 bits; op[1:0] != 2'b11 is always illegal.
// - Registered outputs:
//   - Latency is 1 cycle: ImmSrcR, FmtR and IllegalR reflect op as sampled at the previous rising edge.
//   - reset high at an edge forces ImmSrcR = 000, FmtR = 6'b000000, IllegalR = 0.
//   - Reset overrides that edge's decode, including when it is asserted mid-stream.
//   - The first edge after reset deasserts loads the decode of the current op.
// - FmtR is exactly one-hot for legal opcodes and all-zero when IllegalR = 1.
// - Back-to-back op changes on every cycle are fully supported; there is no handshake and no stall.
// TESTING
// - Combinational sweep, checked after each 10 ns step:
//   - 0010011 -> 000, 0110011 -> 000, 1100011 -> 010
//   - 0100011 -> 001, 0000011 -> 000, 1101111 -> 011, 0110111 -> 100
// - Program-order replay of addi, addi, addi, or, and, add, beq, slt, beq, addi, slt, add, sub,
//   sw, lw, add, jal, addi, add, sw, lui, beq: ImmSrc matches the table on every step.
// - Registered path:
//   - op = 0100011 at edge k -> ImmSrcR = 001, FmtR = 6'b000100 after edge k.
//   - Changing op between edges does not affect ImmSrcR.
// - Reset: hold reset = 1 with op = 1101111 -> ImmSrcR = 000, FmtR = 0, IllegalR = 0; combinational ImmSrc = 011.
// - Illegal opcodes:
//   - op = 1111111 or 0000000 -> ImmSrc = 000, IllegalR = 1 next edge.
//   - With EXT_OPS = 0: op = 0010111 -> IllegalR = 1.
//   - With EXT_OPS = 1: op = 0010111 -> ImmSrc = 100, FmtR = 6'b100000.
// - Exhaustive: all 128 op values vs the reference table; FmtR is one-hot or zero, never multi-hot.

Source files
------------

// File: rtl/instr_decoder_if.sv
// Opcode-in / decode-out bundle between the core controller and the immediate-format decoder.
interface instr_decoder_if;
   logic [6:0] op;
   logic [2:0] ImmSrc;
   logic [2:0] ImmSrcR;
   logic [5:0] FmtR;
   logic       IllegalR;

   modport master (output op, input ImmSrc, input ImmSrcR, input FmtR, input IllegalR);
   modport slave  (input op, output ImmSrc, output ImmSrcR, output FmtR, output IllegalR);
endinterface

// File: rtl/instr_decoder.sv
// RV32I immediate-format decoder: zero-latency ImmSrc plus a registered copy,
// one-hot format class {U,J,B,S,I,R} and illegal flag for the controller FSM.
module instr_decoder #(
   parameter bit         EXT_OPS        = 1'b1,
   parameter logic [2:0] DEFAULT_IMMSRC = 3'b000
) (
   input logic            clk,
   input logic            reset,
   instr_decoder_if.slave bus
);
   typedef struct packed {
      logic [2:0] imm;
      logic [5:0] fmt;
      logic       illegal;
   } dec_t;

   localparam dec_t DEC_ILL = '{imm: DEFAULT_IMMSRC, fmt: 6'b000000, illegal: 1'b1};
   localparam dec_t DEC_I   = '{imm: 3'b000, fmt: 6'b000010, illegal: 1'b0};
   localparam dec_t DEC_S   = '{imm: 3'b001, fmt: 6'b000100, illegal: 1'b0};
   localparam dec_t DEC_B   = '{imm: 3'b010, fmt: 6'b001000, illegal: 1'b0};
   localparam dec_t DEC_J   = '{imm: 3'b011, fmt: 6'b010000, illegal: 1'b0};
   localparam dec_t DEC_U   = '{imm: 3'b100, fmt: 6'b100000, illegal: 1'b0};
   localparam dec_t DEC_R   = '{imm: DEFAULT_IMMSRC, fmt: 6'b000001, illegal: 1'b0};

   dec_t dec;

   // X/Z on op matches no item and falls into the illegal default
   always_comb begin
      dec = DEC_ILL;
      case (bus.op)
         7'b0000011,
         7'b0010011: dec = DEC_I;
         7'b1100111: dec = EXT_OPS ? DEC_I : DEC_ILL;
         7'b0100011: dec = DEC_S;
         7'b1100011: dec = DEC_B;
         7'b1101111: dec = DEC_J;
         7'b0110111: dec = DEC_U;
         7'b0010111: dec = EXT_OPS ? DEC_U : DEC_ILL;
         7'b0110011: dec = DEC_R;
         default:    dec = DEC_ILL;
      endcase
   end

   assign bus.ImmSrc = dec.imm;

   always_ff @(posedge clk) begin
      if (reset) begin
         bus.ImmSrcR  <= 3'b000;
         bus.FmtR     <= 6'b000000;
         bus.IllegalR <= 1'b0;
      end else begin
         bus.ImmSrcR  <= dec.imm;
         bus.FmtR     <= dec.fmt;
         bus.IllegalR <= dec.illegal;
      end
   end
endmodule

// File: tb/tb_instr_decoder.sv
// Randomized + directed bench for instr_decoder, both EXT_OPS settings, against a table-driven model.
module tb_instr_decoder;
   logic       clk = 1'b0;
   logic       reset;
   logic [6:0] op;
   int         tests = 0;
   int         errors = 0;

   always #5 clk = ~clk;

   instr_decoder_if b1 ();
   instr_decoder_if b0 ();
   assign b1.op = op;
   assign b0.op = op;

   instr_decoder #(.EXT_OPS(1'b1), .DEFAULT_IMMSRC(3'b000)) dut1 (.clk(clk), .reset(reset), .bus(b1));
   instr_decoder #(.EXT_OPS(1'b0), .DEFAULT_IMMSRC(3'b000)) dut0 (.clk(clk), .reset(reset), .bus(b0));

   typedef struct {
      logic [2:0] imm;
      logic [5:0] fmt;
      logic       ill;
   } ref_t;

   // Legal opcode list; class index is the FmtR bit (0=R,1=I,2=S,3=B,4=J,5=U)
   localparam int NLEG = 9;
   localparam logic [6:0] LOPS [NLEG] = '{7'b0000011, 7'b0010011, 7'b1100111, 7'b0100011,
                                          7'b1100011, 7'b1101111, 7'b0110111, 7'b0010111, 7'b0110011};
   localparam int         LCLS [NLEG] = '{1, 1, 1, 2, 3, 4, 5, 5, 0};
   localparam bit         LEXT [NLEG] = '{0, 0, 1, 0, 0, 0, 0, 1, 0};
   localparam logic [2:0] DEF = 3'b000;

   function automatic ref_t model(logic [6:0] o, bit ext);
      ref_t r;
      r.imm = DEF; r.fmt = 6'b0; r.ill = 1'b1;
      for (int i = 0; i < NLEG; i++)
         if (LOPS[i] === o && (ext || !LEXT[i])) begin
            r.ill = 1'b0;
            r.fmt = 6'(1) << LCLS[i];
            r.imm = (LCLS[i] == 0) ? DEF : 3'(LCLS[i] - 1);
         end
      return r;
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (op=%b t=%0t)", nm, act, exp, op, $time);
      end
   endtask

   // Expected registered state, built from what op/reset were at each edge
   ref_t e1, e0;
   bit   armed = 1'b0;
   always @(posedge clk) begin
      if (reset) begin
         e1 <= '{3'b000, 6'b000000, 1'b0};
         e0 <= '{3'b000, 6'b000000, 1'b0};
         armed <= 1'b1;
      end else begin
         e1 <= model(op, 1'b1);
         e0 <= model(op, 1'b0);
      end
   end

   ref_t m1, m0;
   always @(negedge clk) begin
      m1 = model(op, 1'b1);
      m0 = model(op, 1'b0);
      chk("imm_ext1", 32'(b1.ImmSrc), 32'(m1.imm));
      chk("imm_ext0", 32'(b0.ImmSrc), 32'(m0.imm));
      if (armed) begin
         chk("immr_ext1", 32'(b1.ImmSrcR), 32'(e1.imm));
         chk("fmtr_ext1", 32'(b1.FmtR), 32'(e1.fmt));
         chk("ill_ext1", 32'(b1.IllegalR), 32'(e1.ill));
         chk("immr_ext0", 32'(b0.ImmSrcR), 32'(e0.imm));
         chk("fmtr_ext0", 32'(b0.FmtR), 32'(e0.fmt));
         chk("ill_ext0", 32'(b0.IllegalR), 32'(e0.ill));
         chk("onehot_ext1", 32'($countones(b1.FmtR) <= 1), 32'd1);
         chk("onehot_ext0", 32'($countones(b0.FmtR) <= 1), 32'd1);
      end
   end

   task automatic drive(logic [6:0] o);
      @(posedge clk);
      #2 op = o;
   endtask

   logic [6:0] sweep [7] = '{7'b0010011, 7'b0110011, 7'b1100011, 7'b0100011,
                            7'b0000011, 7'b1101111, 7'b0110111};
   logic [2:0] sweep_exp [7] = '{3'b000, 3'b000, 3'b010, 3'b001, 3'b000, 3'b011, 3'b100};
   logic [6:0] prog [22] = '{7'b0010011, 7'b0010011, 7'b0010011, 7'b0110011, 7'b0110011,
                           7'b0110011, 7'b1100011, 7'b0110011, 7'b1100011, 7'b0010011,
                           7'b0110011, 7'b0110011, 7'b0110011, 7'b0100011, 7'b0000011,
                           7'b0110011, 7'b1101111, 7'b0010011, 7'b0110011, 7'b0100011,
                           7'b0110111, 7'b1100011};

   initial begin
      ref_t t;
      // Pin the model to hand-computed values
      t = model(7'b0100011, 1'b1); chk("model_sw_imm", 32'(t.imm), 32'd1); chk("model_sw_fmt", 32'(t.fmt), 32'h04);
      t = model(7'b0010111, 1'b0); chk("model_auipc0_ill", 32'(t.ill), 32'd1);
      t = model(7'b0010111, 1'b1); chk("model_auipc1_fmt", 32'(t.fmt), 32'h20);
      t = model(7'b0110011, 1'b1); chk("model_r_fmt", 32'(t.fmt), 32'h01);
      t = model(7'b1100011, 1'b1); chk("model_b_imm", 32'(t.imm), 32'd2);

      reset = 1'b1;
      op = 7'b1101111;
      repeat (3) @(posedge clk);
      #2;
      chk("rst_immr", 32'(b1.ImmSrcR), 32'd0);
      chk("rst_fmtr", 32'(b1.FmtR), 32'd0);
      chk("rst_ill", 32'(b1.IllegalR), 32'd0);
      chk("rst_imm_comb", 32'(b1.ImmSrc), 32'd3);

      reset = 1'b0;
      op = 7'b0100011;
      @(posedge clk);
      #2;
      chk("sw_immr", 32'(b1.ImmSrcR), 32'd1);
      chk("sw_fmtr", 32'(b1.FmtR), 32'h04);
      op = 7'b1101111;
      #5;
      chk("midcycle_immr", 32'(b1.ImmSrcR), 32'd1);

      for (int i = 0; i < 7; i++) begin
         drive(sweep[i]);
         #1 chk("sweep", 32'(b1.ImmSrc), 32'(sweep_exp[i]));
      end
      for (int i = 0; i < 22; i++) drive(prog[i]);

      drive(7'b1111111);
      #1 chk("ill7f_imm", 32'(b1.ImmSrc), 32'd0);
      @(posedge clk); #2 chk("ill7f_illr", 32'(b1.IllegalR), 32'd1);
      op = 7'b0000000;
      #1 chk("ill00_imm", 32'(b1.ImmSrc), 32'd0);
      @(posedge clk); #2 chk("ill00_illr", 32'(b1.IllegalR), 32'd1);
      op = 7'b0010111;
      #1 chk("auipc_imm1", 32'(b1.ImmSrc), 32'd4);
      @(posedge clk); #2;
      chk("auipc_fmtr1", 32'(b1.FmtR), 32'h20);
      chk("auipc_ill0", 32'(b0.IllegalR), 32'd1);
      chk("auipc_fmtr0", 32'(b0.FmtR), 32'd0);

      for (int i = 0; i < 128; i++) drive(7'(i));

      for (int i = 0; i < 400; i++) begin
         @(posedge clk);
         #2;
         reset = ($urandom_range(15) == 0);
         if ($urandom_range(1)) op = LOPS[$urandom_range(NLEG - 1)];
         else op = 7'($urandom);
      end

      drive(7'b1101111);
      reset = 1'b0;
      @(posedge clk); #2 reset = 1'b1;
      @(posedge clk); #2;
      chk("midrst_immr", 32'(b1.ImmSrcR), 32'd0);
      chk("midrst_fmtr", 32'(b1.FmtR), 32'd0);
      reset = 1'b0;
      @(posedge clk); #2 chk("postrst_immr", 32'(b1.ImmSrcR), 32'd3);
      repeat (2) @(posedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $display("[TB] %0d tests run, %0d failed", tests, errors + 1);
      $fatal(1);
   end
endmodule
